mem_stage_lsu: RTL and testbench

MEM-stage load/store unit plus MEM/WB pipeline register. Consumes EX/MEM outputs, performs one data-memory access per load/store over a req/ack bus, stalls the pipe until completion.

---
 rtl/mem_stage_lsu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM-stage load/store unit with the MEM/WB pipeline register.
//
// Takes the EX/MEM outputs. A load or store issues one data-memory access over
// a req/ack bus and holds the pipe (Stall_M) until the access completes. Store
// data is replicated across the byte lanes with matching byte enables. Load
// data is selected from its lane and sign- or zero-extended. Results are
// registered for WB.
//
// Parameters:
//   WIDTH        datapath/address width. The lane logic assumes 32.
//   ACK_TIMEOUT  maximum number of BUSY cycles before the access is aborted (>= 2).
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   Valid_M .. PCPlus4_M           EX/MEM inputs (valid, rd write, result select,
//                                  store, funct3, address/ALU result, rs2, rd, PC+4)
//   Stall_M                        holds IF..EX/MEM while an access is in flight
//   dmem_req/we/addr/be/wdata      data bus request, registered, stable while BUSY
//   dmem_ack, dmem_rdata           completion handshake; rdata is valid with ack
//   RegWrite_W .. PCPlus4_W        MEM/WB register outputs
//   err_W                          {misaligned, bus_timeout}, valid with its instruction
//
// Optional build macro:
//   MISALIGN_TRAP_EN  When defined, a misaligned LH/LHU/SH/LW/SW does not go to
//                     the bus and retires next edge with err_W[1] set. When
//                     undefined, the low address bits are ignored and the
//                     access is silently aligned.
module mem_stage_lsu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_M,
  input  logic             RegWrite_M,
  input  logic [1:0]       ResultSrc_M,
  input  logic             MemWrite_M,
  input  logic [2:0]       funct3_M,
  input  logic [WIDTH-1:0] ALUResult_M,
  input  logic [WIDTH-1:0] WriteData_M,
  input  logic [4:0]       Rd_M,
  input  logic [WIDTH-1:0] PCPlus4_M,
  output logic             Stall_M,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             RegWrite_W,
  output logic [1:0]       ResultSrc_W,
  output logic [WIDTH-1:0] ALUResult_W,
  output logic [WIDTH-1:0] ReadData_W,
  output logic [4:0]       Rd_W,
  output logic [WIDTH-1:0] PCPlus4_W,
  output logic [1:0]       err_W
);

  localparam int unsigned   CW       = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  // Instruction held for the duration of the access
  logic [2:0]       f3_q, f3_d;
  logic             rw_h_q, rw_h_d;
  logic [1:0]       rs_h_q, rs_h_d;
  logic [WIDTH-1:0] alu_h_q, alu_h_d;
  logic [4:0]       rd_h_q, rd_h_d;
  logic [WIDTH-1:0] pc4_h_q, pc4_h_d;
  // MEM/WB register
  logic             regwrite_w_q, regwrite_w_d;
  logic [1:0]       resultsrc_w_q, resultsrc_w_d;
  logic [WIDTH-1:0] aluresult_w_q, aluresult_w_d;
  logic [WIDTH-1:0] readdata_w_q, readdata_w_d;
  logic [4:0]       rd_w_q, rd_w_d;
  logic [WIDTH-1:0] pcplus4_w_q, pcplus4_w_d;
  logic [1:0]       err_w_q, err_w_d;

  logic             access, size_byte, size_half, misalign, mis_trap, launch;
  logic [3:0]       be_calc;
  logic [WIDTH-1:0] wdata_calc, ld_ext;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  // Decode of the instruction currently presented on the EX/MEM inputs
  always_comb begin
    access    = Valid_M & (MemWrite_M | (ResultSrc_M == 2'b01));
    size_byte = (funct3_M[1:0] == 2'b00);
    size_half = (funct3_M[1:0] == 2'b01);
`ifdef MISALIGN_TRAP_EN
    misalign  = size_half ? ALUResult_M[0] : (!size_byte & (ALUResult_M[1:0] != 2'b00));
`else
    misalign  = 1'b0;
`endif
    mis_trap  = access & misalign;
    launch    = access & ~misalign;

    if (size_byte) begin
      be_calc    = 4'b0001 << ALUResult_M[1:0];
      wdata_calc = {(WIDTH/8){WriteData_M[7:0]}};
    end else if (size_half) begin
      be_calc    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {(WIDTH/16){WriteData_M[15:0]}};
    end else begin
      be_calc    = 4'b1111;
      wdata_calc = WriteData_M;
    end
  end

  // Lane selection and extension use the held address, not the live inputs
  always_comb begin
    ld_byte = dmem_rdata[{alu_h_q[1:0], 3'b000} +: 8];
    ld_half = dmem_rdata[{alu_h_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    timeout_d     = timeout_q;
    rdata_d       = rdata_q;
    f3_d          = f3_q;
    rw_h_d        = rw_h_q;
    rs_h_d        = rs_h_q;
    alu_h_d       = alu_h_q;
    rd_h_d        = rd_h_q;
    pc4_h_d       = pc4_h_q;
    regwrite_w_d  = regwrite_w_q;
    resultsrc_w_d = resultsrc_w_q;
    aluresult_w_d = aluresult_w_q;
    readdata_w_d  = readdata_w_q;
    rd_w_d        = rd_w_q;
    pcplus4_w_d   = pcplus4_w_q;
    err_w_d       = err_w_q;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d      = S_BUSY;
          req_d        = 1'b1;
          cnt_d        = '0;
          timeout_d    = 1'b0;
          rdata_d      = '0;
          we_d         = MemWrite_M;
          be_d         = be_calc;
          wdata_d      = wdata_calc;
          f3_d         = funct3_M;
          rw_h_d       = RegWrite_M;
          rs_h_d       = ResultSrc_M;
          alu_h_d      = ALUResult_M;
          rd_h_d       = Rd_M;
          pc4_h_d      = PCPlus4_M;
          // WB sees a bubble while the access is outstanding
          regwrite_w_d = 1'b0;
          err_w_d      = '0;
        end else begin
          // Pass-through: non-access, invalid, or trapped misaligned access
          regwrite_w_d  = Valid_M & RegWrite_M & ~mis_trap;
          resultsrc_w_d = ResultSrc_M;
          aluresult_w_d = ALUResult_M;
          readdata_w_d  = '0;
          rd_w_d        = Rd_M;
          pcplus4_w_d   = PCPlus4_M;
          err_w_d       = {mis_trap, 1'b0};
        end
      end
      S_BUSY: begin
        regwrite_w_d = 1'b0;
        err_w_d      = '0;
        cnt_d        = cnt_q + CW'(1);
        // An ack in the final counted cycle still completes the access
        if (dmem_ack) begin
          rdata_d = we_q ? '0 : ld_ext;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          req_d     = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        regwrite_w_d  = rw_h_q & ~timeout_q;
        resultsrc_w_d = rs_h_q;
        aluresult_w_d = alu_h_q;
        readdata_w_d  = timeout_q ? '0 : rdata_q;
        rd_w_d        = rd_h_q;
        pcplus4_w_d   = pc4_h_q;
        err_w_d       = {1'b0, timeout_q};
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      timeout_q     <= 1'b0;
      rdata_q       <= '0;
      f3_q          <= '0;
      rw_h_q        <= 1'b0;
      rs_h_q        <= '0;
      alu_h_q       <= '0;
      rd_h_q        <= '0;
      pc4_h_q       <= '0;
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= '0;
      aluresult_w_q <= '0;
      readdata_w_q  <= '0;
      rd_w_q        <= '0;
      pcplus4_w_q   <= '0;
      err_w_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      timeout_q     <= timeout_d;
      rdata_q       <= rdata_d;
      f3_q          <= f3_d;
      rw_h_q        <= rw_h_d;
      rs_h_q        <= rs_h_d;
      alu_h_q       <= alu_h_d;
      rd_h_q        <= rd_h_d;
      pc4_h_q       <= pc4_h_d;
      regwrite_w_q  <= regwrite_w_d;
      resultsrc_w_q <= resultsrc_w_d;
      aluresult_w_q <= aluresult_w_d;
      readdata_w_q  <= readdata_w_d;
      rd_w_q        <= rd_w_d;
      pcplus4_w_q   <= pcplus4_w_d;
      err_w_q       <= err_w_d;
    end
  end

  assign Stall_M     = (state_q == S_BUSY) | ((state_q == S_IDLE) & launch);
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = {alu_h_q[WIDTH-1:2], 2'b00};
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign RegWrite_W  = regwrite_w_q;
  assign ResultSrc_W = resultsrc_w_q;
  assign ALUResult_W = aluresult_w_q;
  assign ReadData_W  = readdata_w_q;
  assign Rd_W        = rd_w_q;
  assign PCPlus4_W   = pcplus4_w_q;
  assign err_W       = err_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed cases followed by randomized
// operations, checked against an arithmetic model of the access rules.
module tb_mem_stage_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_M, RegWrite_M, MemWrite_M;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  funct3_M;
  logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]  Rd_M;
  logic        Stall_M, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        RegWrite_W;
  logic [1:0]  ResultSrc_W, err_W;
  logic [31:0] ALUResult_W, ReadData_W, PCPlus4_W;
  logic [4:0]  Rd_W;

  int unsigned total = 0, passed = 0, failed = 0;

  mem_stage_lsu #(.WIDTH(32), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Valid_M(Valid_M), .RegWrite_M(RegWrite_M),
    .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M), .funct3_M(funct3_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .Rd_M(Rd_M),
    .PCPlus4_M(PCPlus4_M), .Stall_M(Stall_M), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W), .ALUResult_W(ALUResult_W),
    .ReadData_W(ReadData_W), .Rd_W(Rd_W), .PCPlus4_W(PCPlus4_W), .err_W(err_W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sz_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (a % sz_of(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
    int sz = sz_of(f3);
    return ((a % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] size_mask(input int sz);
    return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = sz_of(f3);
    return 4'(((1 << sz) - 1) << lane_base(f3, a));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = sz_of(f3);
    logic [31:0] m = size_mask(sz);
    logic [31:0] r = '0;
    for (int k = 0; k < 4 / sz; k++) r |= (wd & m) << (8 * sz * k);
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int sz = sz_of(f3);
    logic [31:0] m = size_mask(sz);
    logic [31:0] v = (w >> (8 * lane_base(f3, a))) & m;
    if (sz < 4 && !f3[2] && v[8*sz-1]) v |= ~m;
    return v;
  endfunction

  // One instruction through MEM: drives the inputs, acts as the memory
  // (ack in BUSY cycle ack_at, never if ack_at < 0), and checks the bus
  // and the WB result. Returns at the negedge after WB has loaded.
  task automatic do_op(input logic v, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdw, input int ack_at, input logic rw,
                       input logic [4:0] rd, input logic [31:0] pc4,
                       output logic [3:0] o_be, output logic [31:0] o_wdata,
                       output logic [31:0] o_addr);
    logic acc, mis, to;
    Valid_M = v; MemWrite_M = mw; ResultSrc_M = rs; funct3_M = f3;
    ALUResult_M = a; WriteData_M = wd; RegWrite_M = rw; Rd_M = rd; PCPlus4_M = pc4;
    dmem_ack = 1'b0; dmem_rdata = rdw;
    acc = v & (mw | (rs == 2'b01));
    mis = acc & exp_mis(f3, a);
    to  = acc & !mis & ((ack_at < 0) || (ack_at >= TO));
    o_be = '0; o_wdata = '0; o_addr = '0;
    #1;
    if (!acc || mis) begin
      chk("stall_passthru", Stall_M, 1'b0);
      chk("req_passthru", dmem_req, 1'b0);
      @(negedge clk);
    end else begin
      chk("stall_launch", Stall_M, 1'b1);
      chk("req_launch", dmem_req, 1'b0);
      for (int n = 0; n < TO; n++) begin
        @(negedge clk);
        chk("req_busy", dmem_req, 1'b1);
        chk("stall_busy", Stall_M, 1'b1);
        if (n == 0) begin
          o_be = dmem_be; o_wdata = dmem_wdata; o_addr = dmem_addr;
          chk("bus_we", dmem_we, mw);
          chk("bus_addr", dmem_addr, a & ~32'h3);
          chk("bus_be", dmem_be, exp_be(f3, a));
          if (mw) chk("bus_wdata", dmem_wdata, exp_wdata(f3, wd));
        end else begin
          chk("bus_stable", {dmem_be, dmem_we}, {o_be, mw});
          chk("bus_addr_stable", dmem_addr, o_addr);
        end
        dmem_ack = (n == ack_at);
        if (dmem_ack || n == TO - 1) break;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("stall_done", Stall_M, 1'b0);
      chk("req_done", dmem_req, 1'b0);
      @(negedge clk);
    end
    chk("wb_regwrite", RegWrite_W, v & rw & ~mis & ~to);
    chk("wb_err", err_W, {mis, to});
    chk("wb_rd", Rd_W, rd);
    chk("wb_resultsrc", ResultSrc_W, rs);
    chk("wb_alu", ALUResult_W, a);
    chk("wb_pc4", PCPlus4_W, pc4);
    if (acc && !mis && !to && !mw) chk("wb_readdata", ReadData_W, exp_load(f3, a, rdw));
  endtask

  logic [3:0]  obe;
  logic [31:0] owd, oad;

  initial begin
    rst = 1'b1;
    Valid_M = 0; RegWrite_M = 0; MemWrite_M = 0; ResultSrc_M = 0; funct3_M = 0;
    ALUResult_M = 0; WriteData_M = 0; Rd_M = 0; PCPlus4_M = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_regwrite", RegWrite_W, 1'b0);
    chk("rst_err", err_W, 2'b00);
    chk("rst_alu", ALUResult_W, 32'h0);
    chk("rst_readdata", ReadData_W, 32'h0);
    chk("rst_misc", {Rd_W, ResultSrc_W}, 7'h0);
    chk("rst_pc4", PCPlus4_W, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // SW 0xDEADBEEF @0x100, ack in first BUSY cycle
    do_op(1, 1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 1, 5'd3, 32'h404, obe, owd, oad);
    chk("sw_be", obe, 4'b1111);
    chk("sw_wdata", owd, 32'hDEADBEEF);
    // Loads from a word with only the top bit set
    do_op(1, 0, 2'b01, 3'b000, 32'h103, 0, 32'h80000000, 1, 1, 5'd4, 32'h408, obe, owd, oad);
    chk("lb_data", ReadData_W, 32'hFFFFFF80);
    do_op(1, 0, 2'b01, 3'b100, 32'h103, 0, 32'h80000000, 2, 1, 5'd5, 32'h40C, obe, owd, oad);
    chk("lbu_data", ReadData_W, 32'h00000080);
    do_op(1, 0, 2'b01, 3'b001, 32'h102, 0, 32'h80000000, 0, 1, 5'd6, 32'h410, obe, owd, oad);
    chk("lh_data", ReadData_W, 32'hFFFF8000);
    // Narrow stores
    do_op(1, 1, 2'b00, 3'b000, 32'h102, 32'h000000A5, 0, 0, 0, 5'd0, 32'h414, obe, owd, oad);
    chk("sb_be", obe, 4'b0100);
    chk("sb_wdata", owd, 32'hA5A5A5A5);
    do_op(1, 1, 2'b00, 3'b001, 32'h102, 32'h00001234, 0, 1, 0, 5'd0, 32'h418, obe, owd, oad);
    chk("sh_be", obe, 4'b1100);
    chk("sh_wdata", owd, 32'h12341234);
    // Load never acked: timeout
    do_op(1, 0, 2'b01, 3'b010, 32'h200, 0, 32'h12345678, -1, 1, 5'd7, 32'h41C, obe, owd, oad);
    chk("to_err", err_W, 2'b01);
    chk("to_regwrite", RegWrite_W, 1'b0);
    // Ack in the last allowed cycle wins over the timeout
    do_op(1, 0, 2'b01, 3'b010, 32'h204, 0, 32'hCAFEF00D, TO - 1, 1, 5'd8, 32'h420, obe, owd, oad);
    chk("late_ack_err", err_W, 2'b00);
    chk("late_ack_data", ReadData_W, 32'hCAFEF00D);
    // Misaligned word load
    do_op(1, 0, 2'b01, 3'b010, 32'h101, 0, 32'h11223344, 0, 1, 5'd9, 32'h424, obe, owd, oad);
`ifdef MISALIGN_TRAP_EN
    chk("lw_mis_err", err_W, 2'b10);
    chk("lw_mis_regwrite", RegWrite_W, 1'b0);
`else
    chk("lw_mis_addr", oad, 32'h100);
    chk("lw_mis_be", obe, 4'b1111);
`endif
    // ALU result and an invalid slot
    do_op(1, 0, 2'b00, 3'b000, 32'h55AA, 0, 0, 0, 1, 5'd10, 32'h428, obe, owd, oad);
    do_op(0, 1, 2'b01, 3'b010, 32'h1234, 0, 0, 0, 1, 5'd11, 32'h42C, obe, owd, oad);

    // Reset in the middle of an access
    Valid_M = 1; MemWrite_M = 0; ResultSrc_M = 2'b01; funct3_M = 3'b010;
    ALUResult_M = 32'h300; RegWrite_M = 1; Rd_M = 5'd12; PCPlus4_M = 32'h430;
    @(negedge clk);
    chk("rst_mid_req_before", dmem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", dmem_req, 1'b0);
    chk("rst_mid_alu", ALUResult_W, 32'h0);
    chk("rst_mid_pc4", PCPlus4_W, 32'h0);
    chk("rst_mid_rd", Rd_W, 5'd0);
    Valid_M = 0;
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 0, 2'b01, 3'b101, 32'h302, 0, 32'h9ABC0000, 1, 1, 5'd13, 32'h434, obe, owd, oad);
    chk("post_rst_lhu", ReadData_W, 32'h00009ABC);

    // Randomized operations
    for (int i = 0; i < 80; i++) begin
      logic v, mw, rw;
      logic [1:0] rs;
      int r, ack_at;
      v  = ($urandom_range(0, 7) != 0);
      mw = ($urandom_range(0, 2) == 0);
      rs = mw ? 2'b00 : 2'($urandom_range(0, 3));
      rw = 1'($urandom);
      r  = $urandom_range(0, 9);
      ack_at = (r < 7) ? $urandom_range(0, 3) : ((r == 7) ? TO - 1 : -1);
      do_op(v, mw, rs, 3'($urandom), $urandom, $urandom, $urandom, ack_at, rw,
            5'($urandom), $urandom, obe, owd, oad);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
